uart_sdram_cmd_engine: RTL and testbench

//  Parametrised successor to the serial user command parser: sits between the UART and the SDRAM controller.
//  It buffers host bytes, decodes framed commands with configurable length/address field widths, and drives the
//  one-access-at-a-time SDRAM port. Adds FILL, a 32-bit VERSION word, zero-length handling and a header timeout.

---
 rtl/uart_cmd_pkg.sv | 39 +++
 rtl/uart_sdram_cmd_engine_fifo.sv | 45 ++++
 rtl/uart_sdram_cmd_engine.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_uart_sdram_cmd_engine.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and wire-protocol characters for the UART-to-SDRAM command engine.
package uart_cmd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE, ST_CMD, ST_LEN, ST_ADDR,
        ST_RD_ISSUE, ST_RD_WAIT,
        ST_WR_GET, ST_WR_WAIT,
        ST_FILL_GET, ST_FILL_ISSUE, ST_FILL_WAIT,
        ST_VER, ST_RESP
    } state_t;

    // Command characters
    localparam logic [7:0] CH_START   = 8'h21; // '!'
    localparam logic [7:0] CH_READ    = 8'h52; // 'R'
    localparam logic [7:0] CH_WRITE   = 8'h57; // 'W'
    localparam logic [7:0] CH_FILL    = 8'h46; // 'F'
    localparam logic [7:0] CH_VER     = 8'h56; // 'V'

    // Response characters
    localparam logic [7:0] CH_WR_OK   = 8'h77; // 'w'
    localparam logic [7:0] CH_FILL_OK = 8'h66; // 'f'
    localparam logic [7:0] CH_BAD     = 8'h3F; // '?'
    localparam logic [7:0] CH_TMO     = 8'h40; // '@'

    // One byte-lane write on the 16-bit SDRAM port
    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  mask;
    } sd_wr_t;

    // Place a byte in the lane selected by the address LSB
    function automatic sd_wr_t lane_write(input logic [7:0] b, input logic lane);
        sd_wr_t w;
        w.data = lane ? {b, 8'h00} : {8'h00, b};
        w.mask = lane ? 2'b10 : 2'b01;
        return w;
    endfunction

endpackage

// File: rtl/uart_sdram_cmd_engine_fifo.sv
// Show-ahead byte fifo buffering host bytes; pushes while full are dropped.
module uart_sdram_cmd_engine_fifo #(
    parameter int unsigned NUM   = 512,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data_c,
    output logic             o_empty_c,
    output logic             o_full_c
);
    localparam int unsigned AW = $clog2(NUM);

    logic [WIDTH-1:0] r_mem [NUM];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty_c = (r_wr_ptr == r_rd_ptr);
    assign o_full_c  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push_ok = i_push && !o_full_c;
    assign w_pop_ok  = i_pop && !o_empty_c;
    assign o_data_c  = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset flushes contents
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/uart_sdram_cmd_engine.sv
// Framed host command decoder driving a one-access-at-a-time SDRAM port.
module uart_sdram_cmd_engine
    import uart_cmd_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = 24,
    parameter int unsigned ADDR_BYTES = 4,
    parameter int unsigned LEN_BYTES  = 4,
    parameter int unsigned FIFO_DEPTH = 512,
    parameter logic [31:0] VERSION    = 32'h0002_0000,
    parameter int unsigned TIMEOUT    = 1_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           uart_rxd,
    input  logic                 uart_rxd_strobe,
    output logic [7:0]           uart_txd,
    output logic                 uart_txd_strobe,
    input  logic                 uart_txd_ready,
    output logic [ADDR_BITS-1:0] sd_addr,
    output logic [15:0]          sd_wr_data,
    output logic [1:0]           sd_wr_mask,
    input  logic [15:0]          sd_rd_data,
    input  logic                 sd_ack,
    input  logic                 sd_idle,
    output logic                 sd_we,
    output logic                 sd_enable
);
    localparam int unsigned LW = LEN_BYTES * 8;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_t                r_state;
    logic [7:0]            r_cmd;
    logic [LW-1:0]         r_len;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [1:0]            r_cnt;
    logic [31:0]           r_ver;
    logic [7:0]            r_fill;
    logic                  r_have;
    logic [TW-1:0]         r_tmo;
    logic [7:0]            r_txd;
    logic                  r_txd_strobe;
    sd_wr_t                r_wr;
    logic                  r_we;
    logic                  r_en;

    logic [7:0]            w_rx_byte;
    logic                  w_rx_empty;
    logic                  w_rx_full;
    logic                  w_rx_valid;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_tx_ok;
    logic                  w_issue_ok;
    logic                  w_timed;
    logic                  w_tmo_hit;

    assign uart_txd        = r_txd;
    assign uart_txd_strobe = r_txd_strobe;
    assign sd_addr         = r_addr;
    assign sd_wr_data      = r_wr.data;
    assign sd_wr_mask      = r_wr.mask;
    assign sd_we           = r_we;
    assign sd_enable       = r_en;

    assign w_push     = uart_rxd_strobe && !w_rx_full;
    assign w_rx_valid = !w_rx_empty;
    // A gap cycle after each strobe lets the transmitter drop ready before the next byte
    assign w_tx_ok    = uart_txd_ready && !r_txd_strobe;
    assign w_issue_ok = sd_idle && !r_en;
    assign w_timed    = (r_state == ST_CMD) || (r_state == ST_LEN) || (r_state == ST_ADDR) ||
                        (r_state == ST_WR_GET) || (r_state == ST_FILL_GET);
    assign w_tmo_hit  = w_timed && !w_pop && (r_tmo == TW'(TIMEOUT - 1));

    uart_sdram_cmd_engine_fifo #(
        .NUM   (FIFO_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk       (clk),
        .i_reset   (reset),
        .i_push    (w_push),
        .i_data    (uart_rxd),
        .i_pop     (w_pop),
        .o_data_c  (w_rx_byte),
        .o_empty_c (w_rx_empty),
        .o_full_c  (w_rx_full)
    );

    // Fifo pop decision: bytes are consumed only in states that can act on them now
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            ST_IDLE:                              w_pop = w_rx_valid && ((w_rx_byte == CH_START) || w_tx_ok);
            ST_CMD, ST_LEN, ST_ADDR, ST_FILL_GET: w_pop = w_rx_valid;
            ST_WR_GET:                            w_pop = w_rx_valid && w_issue_ok;
            default:                              w_pop = 1'b0;
        endcase
    end

    // Command FSM with registered UART and SDRAM outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cmd        <= '0;
            r_len        <= '0;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_ver        <= '0;
            r_fill       <= '0;
            r_have       <= 1'b0;
            r_tmo        <= '0;
            r_txd        <= '0;
            r_txd_strobe <= 1'b0;
            r_wr         <= '0;
            r_we         <= 1'b0;
            r_en         <= 1'b0;
        end else begin
            r_txd_strobe <= 1'b0;
            if (!w_timed || w_pop) r_tmo <= '0;
            else                   r_tmo <= r_tmo + TW'(1);

            if (w_tmo_hit) begin
                r_txd   <= CH_TMO;
                r_state <= ST_RESP;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_pop) begin
                            if (w_rx_byte == CH_START) begin
                                r_state <= ST_CMD;
                            end else begin
                                r_txd        <= w_rx_byte;
                                r_txd_strobe <= 1'b1;
                            end
                        end
                    end
                    ST_CMD: begin
                        if (w_pop) begin
                            r_cmd  <= w_rx_byte;
                            r_cnt  <= '0;
                            r_addr <= '0;
                            case (w_rx_byte)
                                CH_READ, CH_WRITE, CH_FILL: r_state <= ST_LEN;
                                CH_VER: begin
                                    r_ver   <= VERSION;
                                    r_state <= ST_VER;
                                end
                                default: begin
                                    r_txd   <= CH_BAD;
                                    r_state <= ST_RESP;
                                end
                            endcase
                        end
                    end
                    ST_LEN: begin
                        if (w_pop) begin
                            r_len <= LW'({r_len, w_rx_byte});
                            r_cnt <= r_cnt + 2'd1;
                            if (r_cnt == 2'(LEN_BYTES - 1)) begin
                                r_cnt   <= '0;
                                r_state <= ST_ADDR;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (w_pop) begin
                            r_addr <= ADDR_BITS'({r_addr, w_rx_byte});
                            r_cnt  <= r_cnt + 2'd1;
                            if (r_cnt == 2'(ADDR_BYTES - 1)) begin
                                r_cnt <= '0;
                                // Zero length: no access; reads have no trailer, writes/fills still acknowledge
                                if (r_len == '0) begin
                                    if (r_cmd == CH_READ) begin
                                        r_state <= ST_IDLE;
                                    end else begin
                                        r_txd   <= (r_cmd == CH_WRITE) ? CH_WR_OK : CH_FILL_OK;
                                        r_state <= ST_RESP;
                                    end
                                end else begin
                                    case (r_cmd)
                                        CH_READ:  r_state <= ST_RD_ISSUE;
                                        CH_WRITE: r_state <= ST_WR_GET;
                                        default:  r_state <= ST_FILL_GET;
                                    endcase
                                end
                            end
                        end
                    end
                    ST_RD_ISSUE: begin
                        if (w_issue_ok && w_tx_ok) begin
                            r_en    <= 1'b1;
                            r_we    <= 1'b0;
                            r_have  <= 1'b0;
                            r_state <= ST_RD_WAIT;
                        end
                    end
                    ST_RD_WAIT: begin
                        if (r_en && sd_ack) begin
                            r_en   <= 1'b0;
                            r_txd  <= r_addr[0] ? sd_rd_data[15:8] : sd_rd_data[7:0];
                            r_have <= 1'b1;
                        end else if (r_have && w_tx_ok) begin
                            r_txd_strobe <= 1'b1;
                            r_have       <= 1'b0;
                            r_addr       <= r_addr + ADDR_BITS'(1);
                            r_len        <= r_len - LW'(1);
                            r_state      <= (r_len == LW'(1)) ? ST_IDLE : ST_RD_ISSUE;
                        end
                    end
                    ST_WR_GET: begin
                        if (w_pop) begin
                            r_wr    <= lane_write(w_rx_byte, r_addr[0]);
                            r_en    <= 1'b1;
                            r_we    <= 1'b1;
                            r_state <= ST_WR_WAIT;
                        end
                    end
                    ST_WR_WAIT: begin
                        if (sd_ack) begin
                            r_en   <= 1'b0;
                            r_we   <= 1'b0;
                            r_addr <= r_addr + ADDR_BITS'(1);
                            r_len  <= r_len - LW'(1);
                            if (r_len == LW'(1)) begin
                                r_txd   <= CH_WR_OK;
                                r_state <= ST_RESP;
                            end else begin
                                r_state <= ST_WR_GET;
                            end
                        end
                    end
                    ST_FILL_GET: begin
                        if (w_pop) begin
                            r_fill  <= w_rx_byte;
                            r_state <= ST_FILL_ISSUE;
                        end
                    end
                    ST_FILL_ISSUE: begin
                        if (w_issue_ok) begin
                            r_wr    <= lane_write(r_fill, r_addr[0]);
                            r_en    <= 1'b1;
                            r_we    <= 1'b1;
                            r_state <= ST_FILL_WAIT;
                        end
                    end
                    ST_FILL_WAIT: begin
                        if (sd_ack) begin
                            r_en   <= 1'b0;
                            r_we   <= 1'b0;
                            r_addr <= r_addr + ADDR_BITS'(1);
                            r_len  <= r_len - LW'(1);
                            if (r_len == LW'(1)) begin
                                r_txd   <= CH_FILL_OK;
                                r_state <= ST_RESP;
                            end else begin
                                r_state <= ST_FILL_ISSUE;
                            end
                        end
                    end
                    ST_VER: begin
                        if (w_tx_ok) begin
                            r_txd        <= r_ver[31:24];
                            r_ver        <= {r_ver[23:0], 8'h00};
                            r_txd_strobe <= 1'b1;
                            r_cnt        <= r_cnt + 2'd1;
                            if (r_cnt == 2'd3) begin
                                r_cnt   <= '0;
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    ST_RESP: begin
                        if (w_tx_ok) begin
                            r_txd_strobe <= 1'b1;
                            r_state      <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_sdram_cmd_engine.sv
// Scoreboard bench for uart_sdram_cmd_engine with a small SDRAM responder model.
module tb_uart_sdram_cmd_engine;
    import uart_cmd_pkg::*;

    localparam int unsigned TMO = 300;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  uart_rxd = '0;
    logic        uart_rxd_strobe = 1'b0;
    logic [7:0]  uart_txd;
    logic        uart_txd_strobe;
    logic        uart_txd_ready = 1'b1;
    logic [23:0] sd_addr;
    logic [15:0] sd_wr_data;
    logic [1:0]  sd_wr_mask;
    logic [15:0] sd_rd_data = '0;
    logic        sd_ack = 1'b0;
    logic        sd_idle;
    logic        sd_we;
    logic        sd_enable;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
        logic [1:0]  mask;
    } wr_exp_t;

    logic [7:0] exp_tx[$];
    wr_exp_t    exp_wr[$];
    int         checks = 0;
    int         passes = 0;
    int         en_cnt = 0;
    int         tx_cnt = 0;
    logic       prev_en = 1'b0;

    // SDRAM model: byte store indexed by the low address bits (test addresses do not alias)
    logic [7:0] mem [256];
    int         sd_cnt = 0;

    always #5 clk = ~clk;

    uart_sdram_cmd_engine #(
        .ADDR_BITS  (24),
        .ADDR_BYTES (4),
        .LEN_BYTES  (4),
        .FIFO_DEPTH (16),
        .VERSION    (32'h0002_0000),
        .TIMEOUT    (TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .uart_rxd        (uart_rxd),
        .uart_rxd_strobe (uart_rxd_strobe),
        .uart_txd        (uart_txd),
        .uart_txd_strobe (uart_txd_strobe),
        .uart_txd_ready  (uart_txd_ready),
        .sd_addr         (sd_addr),
        .sd_wr_data      (sd_wr_data),
        .sd_wr_mask      (sd_wr_mask),
        .sd_rd_data      (sd_rd_data),
        .sd_ack          (sd_ack),
        .sd_idle         (sd_idle),
        .sd_we           (sd_we),
        .sd_enable       (sd_enable)
    );

    assign sd_idle = (sd_cnt == 0) && !sd_ack;

    // Responder: acks each request three cycles after it is seen
    always @(posedge clk) begin
        sd_ack <= 1'b0;
        if (reset) begin
            sd_cnt <= 0;
        end else if (sd_cnt == 0) begin
            if (sd_enable && !sd_ack) sd_cnt <= 3;
        end else if (sd_cnt == 1) begin
            sd_cnt <= 0;
            sd_ack <= 1'b1;
            if (sd_we) begin
                if (sd_wr_mask[0]) mem[{sd_addr[7:1], 1'b0}] <= sd_wr_data[7:0];
                if (sd_wr_mask[1]) mem[{sd_addr[7:1], 1'b1}] <= sd_wr_data[15:8];
            end else begin
                sd_rd_data <= {mem[{sd_addr[7:1], 1'b1}], mem[{sd_addr[7:1], 1'b0}]};
            end
        end else begin
            sd_cnt <= sd_cnt - 1;
        end
    end

    // Advance to the next falling edge and score whatever the DUT produced
    task automatic tick();
        logic [7:0] e;
        wr_exp_t    w;
        @(negedge clk);
        if (!reset) begin
            if (uart_txd_strobe) begin
                tx_cnt++;
                checks++;
                if (exp_tx.size() == 0) begin
                    $display("FAIL tx_byte: got %02h, expected no byte", uart_txd);
                end else begin
                    e = exp_tx.pop_front();
                    if (uart_txd !== e) $display("FAIL tx_byte: got %02h, expected %02h", uart_txd, e);
                    else passes++;
                end
            end
            if (sd_enable && !prev_en) begin
                en_cnt++;
                if (sd_we) begin
                    checks++;
                    if (exp_wr.size() == 0) begin
                        $display("FAIL sd_write: got addr %06h data %04h mask %b, expected none",
                                 sd_addr, sd_wr_data, sd_wr_mask);
                    end else begin
                        w = exp_wr.pop_front();
                        if ({sd_addr, sd_wr_data, sd_wr_mask} !== {w.addr, w.data, w.mask})
                            $display("FAIL sd_write: got addr %06h data %04h mask %b, expected addr %06h data %04h mask %b",
                                     sd_addr, sd_wr_data, sd_wr_mask, w.addr, w.data, w.mask);
                        else passes++;
                    end
                end
            end
        end
        prev_en = sd_enable;
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_rxd        = b;
        uart_rxd_strobe = 1'b1;
        tick();
        uart_rxd_strobe = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] len, input logic [31:0] addr);
        send_byte(CH_START);
        send_byte(cmd);
        for (int i = 3; i >= 0; i--) send_byte(len[8*i +: 8]);
        for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
    endtask

    task automatic push_wr(input logic [23:0] a, input logic [15:0] d, input logic [1:0] m);
        wr_exp_t w;
        w.addr = a;
        w.data = d;
        w.mask = m;
        exp_wr.push_back(w);
    endtask

    task automatic push_version();
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h02);
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h00);
    endtask

    // Run until both queues are empty plus a quiet margin, within a cycle budget
    task automatic wait_drain(input int max_cycles, output bit ok);
        int quiet;
        ok    = 1'b0;
        quiet = 0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (exp_tx.size() == 0 && exp_wr.size() == 0) quiet++;
            else quiet = 0;
            if (quiet >= 20) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (sd_enable !== 1'b0)       $display("FAIL rst_sd_enable: got %b, expected 0", sd_enable);   else passes++;
        checks++; if (uart_txd_strobe !== 1'b0) $display("FAIL rst_txd_strobe: got %b, expected 0", uart_txd_strobe); else passes++;
        checks++; if (uart_txd !== 8'h00)       $display("FAIL rst_txd: got %02h, expected 00", uart_txd);       else passes++;
        checks++; if (sd_addr !== 24'h0)        $display("FAIL rst_sd_addr: got %06h, expected 000000", sd_addr); else passes++;
        checks++; if (sd_we !== 1'b0)           $display("FAIL rst_sd_we: got %b, expected 0", sd_we);           else passes++;
        checks++; if ({sd_wr_data, sd_wr_mask} !== 18'h0)
                      $display("FAIL rst_sd_wr: got data %04h mask %b, expected 0000/00", sd_wr_data, sd_wr_mask); else passes++;
        reset = 1'b0;
        repeat (5) tick();
        checks++; if ({sd_enable, uart_txd_strobe} !== 2'b00)
                      $display("FAIL idle_after_rst: got en %b strobe %b, expected 0 0", sd_enable, uart_txd_strobe); else passes++;
    endtask

    task automatic test_version();
        int e0;
        bit ok;
        e0 = en_cnt;
        push_version();
        send_byte(CH_START);
        send_byte(CH_VER);
        wait_drain(500, ok);
        checks++; if (!ok) $display("FAIL drain_version: %0d tx bytes pending, expected 0", exp_tx.size()); else passes++;
        checks++; if (en_cnt != e0) $display("FAIL version_no_sdram: got %0d requests, expected 0", en_cnt - e0); else passes++;
    endtask

    task automatic test_write();
        bit ok;
        push_wr(24'h000010, 16'h00AA, 2'b01);
        push_wr(24'h000011, 16'h5500, 2'b10);
        exp_tx.push_back(CH_WR_OK);
        send_hdr(CH_WRITE, 32'd2, 32'h0000_0010);
        send_byte(8'hAA);
        send_byte(8'h55);
        wait_drain(500, ok);
        checks++; if (!ok) $display("FAIL drain_write: %0d tx %0d writes pending, expected 0", exp_tx.size(), exp_wr.size()); else passes++;
    endtask

    task automatic test_read();
        int e0;
        int t0;
        bit ok;
        e0 = en_cnt;
        uart_txd_ready = 1'b0;
        exp_tx.push_back(8'hAA);
        exp_tx.push_back(8'h55);
        send_hdr(CH_READ, 32'd2, 32'h0000_0010);
        t0 = tx_cnt;
        repeat (50) tick();
        checks++; if (tx_cnt != t0 || en_cnt != e0)
                      $display("FAIL read_held: got %0d tx %0d requests while not ready, expected 0 0", tx_cnt - t0, en_cnt - e0); else passes++;
        uart_txd_ready = 1'b1;
        wait_drain(500, ok);
        checks++; if (!ok) $display("FAIL drain_read: %0d tx bytes pending, expected 0", exp_tx.size()); else passes++;
        checks++; if (en_cnt - e0 != 2) $display("FAIL read_accesses: got %0d, expected 2", en_cnt - e0); else passes++;
    endtask

    task automatic test_fill_wrap();
        bit ok;
        push_wr(24'hFFFFFF, 16'h7E00, 2'b10);
        push_wr(24'h000000, 16'h007E, 2'b01);
        push_wr(24'h000001, 16'h7E00, 2'b10);
        exp_tx.push_back(CH_FILL_OK);
        send_hdr(CH_FILL, 32'd3, 32'h00FF_FFFF);
        send_byte(8'h7E);
        wait_drain(500, ok);
        checks++; if (!ok) $display("FAIL drain_fill: %0d tx %0d writes pending, expected 0", exp_tx.size(), exp_wr.size()); else passes++;
    endtask

    task automatic test_bad_cmd();
        bit ok;
        exp_tx.push_back(CH_BAD);
        send_byte(CH_START);
        send_byte(8'h58);
        wait_drain(300, ok);
        checks++; if (!ok) $display("FAIL drain_bad_cmd: %0d tx bytes pending, expected 0", exp_tx.size()); else passes++;
    endtask

    task automatic test_timeout();
        bit ok;
        exp_tx.push_back(CH_TMO);
        send_byte(CH_START);
        send_byte(CH_WRITE);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_drain(3 * TMO, ok);
        checks++; if (!ok) $display("FAIL timeout_resp: %0d tx bytes pending, expected 0", exp_tx.size()); else passes++;
        push_version();
        send_byte(CH_START);
        send_byte(CH_VER);
        wait_drain(500, ok);
        checks++; if (!ok) $display("FAIL version_after_tmo: %0d tx bytes pending, expected 0", exp_tx.size()); else passes++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        exp_tx.push_back(8'h61);
        push_version();
        exp_tx.push_back(CH_BAD);
        exp_tx.push_back(8'h71);
        send_byte(8'h61);
        send_byte(CH_START);
        send_byte(CH_VER);
        send_byte(CH_START);
        send_byte(8'h58);
        send_byte(8'h71);
        wait_drain(800, ok);
        checks++; if (!ok) $display("FAIL drain_back_to_back: %0d tx bytes pending, expected 0", exp_tx.size()); else passes++;
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        bit seen;
        push_wr(24'h000020, 16'h0011, 2'b01);
        send_hdr(CH_WRITE, 32'd2, 32'h0000_0020);
        send_byte(8'h11);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (sd_enable) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++; if (!seen) $display("FAIL mid_write_issue: got sd_enable 0, expected 1"); else passes++;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (sd_enable !== 1'b0) $display("FAIL rst_abandon: got sd_enable %b, expected 0", sd_enable); else passes++;
        tick();
        reset = 1'b0;
        tick();
        exp_tx.push_back(8'h5A);
        send_byte(8'h5A);
        wait_drain(300, ok);
        checks++; if (!ok) $display("FAIL echo_after_rst: %0d tx %0d writes pending, expected 0", exp_tx.size(), exp_wr.size()); else passes++;
    endtask

    initial begin
        test_reset();
        test_version();
        test_write();
        test_read();
        test_fill_wrap();
        test_bad_cmd();
        test_timeout();
        test_back_to_back();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
